// File: rtl/zbt_port_arbiter_pkg.sv
// Shared definitions for the ZBT port arbiter: bus timing constants, default widths
// and the per-cycle slot type used by the grant logic.
package zbt_port_arbiter_pkg;

  localparam int ZBT_LAT            = 2;
  localparam int DEF_ADDR_W         = 19;
  localparam int DEF_DATA_W         = 36;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_STARVE_MAX     = 16;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_e;

  // Occupancy counter width: must be able to represent a completely full FIFO.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zbt_port_arbiter_if.sv
// Bundle of the capture-writer, display-reader and ZBT-side signals of the arbiter.
// The arbiter uses the slave view; whoever drives the clients and memory uses master.
interface zbt_port_arbiter_if
  import zbt_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int LVL_W = levelWidth(FIFO_DEPTH);

  logic              ntsc_we;
  logic [ADDR_W-1:0] ntsc_addr;
  logic [DATA_W-1:0] ntsc_data;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              clr_overflow;

  modport slave (
    input  ntsc_we, ntsc_addr, ntsc_data, disp_req, disp_addr, mem_rdata, clr_overflow,
    output disp_gnt, disp_rvalid, disp_rdata, mem_addr, mem_we, mem_wdata,
           fifo_level, overflow
  );

  modport master (
    output ntsc_we, ntsc_addr, ntsc_data, disp_req, disp_addr, mem_rdata, clr_overflow,
    input  disp_gnt, disp_rvalid, disp_rdata, mem_addr, mem_we, mem_wdata,
           fifo_level, overflow
  );

endinterface

// File: rtl/zbt_port_arbiter_wfifo.sv
// Synchronous FIFO holding {addr,data} writer words; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module zbt_port_arbiter_wfifo
  import zbt_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [ADDR_W-1:0]              i_push_addr,
  input  logic [DATA_W-1:0]              i_push_data,
  input  logic                           i_pop,
  output logic [ADDR_W-1:0]              o_head_addr,
  output logic [DATA_W-1:0]              o_head_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [levelWidth(DEPTH)-1:0]   o_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = levelWidth(DEPTH);
  localparam int WORD_W = ADDR_W + DATA_W;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // DEPTH is a power of two, so the pointers wrap simply by overflowing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {i_push_addr, i_push_data};
  end

  assign {o_head_addr, o_head_data} = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT bank between the NTSC capture writer (buffered) and the VGA reader,
// display first, with a starvation guard and ZBT-pipelined write data / read return.
module zbt_port_arbiter
  import zbt_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic               clk,
  input  logic               reset,
  zbt_port_arbiter_if.slave  bus
);
  localparam int LVL_W = levelWidth(FIFO_DEPTH);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [LVL_W-1:0]  w_level;
  slot_e             w_slot;
  logic [SC_W-1:0]   w_starve_nxt;

  logic [SC_W-1:0]   r_starve_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wd_vld [ZBT_LAT];
  logic [DATA_W-1:0] r_wd_dat [ZBT_LAT];
  logic              r_rv     [ZBT_LAT+1];
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_overflow;

  zbt_port_arbiter_wfifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wfifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (bus.ntsc_we),
    .i_push_addr (bus.ntsc_addr),
    .i_push_data (bus.ntsc_data),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // Display wins unless the writer has waited STARVE_MAX grants with data pending.
  always_comb begin
    w_slot = SLOT_IDLE;
    if (bus.disp_req && !(!w_empty && (r_starve_cnt == SC_MAX))) begin
      w_slot = SLOT_READ;
    end else if (!w_empty) begin
      w_slot = SLOT_WRITE;
    end
  end

  assign w_pop  = (w_slot == SLOT_WRITE);
  assign w_drop = bus.ntsc_we & w_full & ~w_pop;

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_empty || (w_slot == SLOT_WRITE)) begin
      w_starve_nxt = '0;
    end else if ((w_slot == SLOT_READ) && (r_starve_cnt != SC_MAX)) begin
      w_starve_nxt = r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Address phase plus the write-data and read-return pipes; reset discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      for (int i = 0; i < ZBT_LAT; i++) begin
        r_wd_vld[i] <= 1'b0;
        r_wd_dat[i] <= '0;
      end
      for (int i = 0; i <= ZBT_LAT; i++) begin
        r_rv[i] <= 1'b0;
      end
    end else begin
      case (w_slot)
        SLOT_READ: begin
          r_mem_addr <= bus.disp_addr;
          r_mem_we   <= 1'b0;
        end
        SLOT_WRITE: begin
          r_mem_addr <= w_head_addr;
          r_mem_we   <= 1'b1;
        end
        default: begin
          r_mem_we   <= 1'b0;
        end
      endcase

      r_wd_vld[0] <= w_pop;
      r_wd_dat[0] <= w_pop ? w_head_data : '0;
      for (int i = 1; i < ZBT_LAT; i++) begin
        r_wd_vld[i] <= r_wd_vld[i-1];
        r_wd_dat[i] <= r_wd_dat[i-1];
      end
      if (r_wd_vld[ZBT_LAT-1]) begin
        r_mem_wdata <= r_wd_dat[ZBT_LAT-1];
      end

      r_rv[0] <= (w_slot == SLOT_READ);
      for (int i = 1; i <= ZBT_LAT; i++) begin
        r_rv[i] <= r_rv[i-1];
      end
      r_rvalid <= r_rv[ZBT_LAT];
      if (r_rv[ZBT_LAT]) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.disp_gnt    = (w_slot == SLOT_READ);
  assign bus.disp_rvalid = r_rvalid;
  assign bus.disp_rdata  = r_rdata;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.fifo_level  = w_level;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Directed bench for zbt_port_arbiter with a pipelined ZBT memory model and read/write
// scoreboards that expect each write and read return at its fixed bus latency.
module tb_zbt_port_arbiter;
  import zbt_port_arbiter_pkg::*;

  localparam int AW    = 19;
  localparam int DW    = 36;
  localparam int DEPTH = 8;
  localparam int SMAX  = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nErrors = 0;
  int   cyc = 0;
  int   rvCount = 0;

  wr_t   writeQ[$];
  pend_t wdQ[$];
  pend_t readQ[$];
  wr_t   monW;
  pend_t monP;

  logic [DW-1:0] memModel [logic [AW-1:0]];
  logic [AW-1:0] mA1, mA2;
  logic          mWe1, mWe2;

  always #5 clk = ~clk;

  zbt_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  zbt_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    return memModel.exists(a) ? memModel[a] : '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input bit expectDrop);
    bus.ntsc_we   = 1'b1;
    bus.ntsc_addr = a;
    bus.ntsc_data = d;
    if (!expectDrop) writeQ.push_back('{a, d});
    tick();
    bus.ntsc_we = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},      bus.disp_gnt, 0);
    checkOutput({tag, "_rvalid"},   bus.disp_rvalid, 0);
    checkOutput({tag, "_rdata"},    bus.disp_rdata, 0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, "_mem_we"},   bus.mem_we, 0);
    checkOutput({tag, "_wdata"},    bus.mem_wdata, 0);
    checkOutput({tag, "_level"},    bus.fifo_level, 0);
    checkOutput({tag, "_overflow"}, bus.overflow, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ZBT model: address in cycle A, read data driven in A+2, write data taken in A+2.
  always @(posedge clk) begin
    if (mWe2) memModel[mA2] = bus.mem_wdata;
    bus.mem_rdata <= lookup(mA1);
    mA1 <= bus.mem_addr;
    mA2 <= mA1;
    mWe1 <= bus.mem_we && !reset;
    mWe2 <= mWe1 && !reset;
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      writeQ.delete();
      wdQ.delete();
      readQ.delete();
    end else begin
      if (bus.mem_we) begin
        if (writeQ.size() == 0) begin
          checkOutput("spurious_we", bus.mem_we, 0);
        end else begin
          monW = writeQ.pop_front();
          checkOutput("wr_addr", bus.mem_addr, monW.addr);
          wdQ.push_back('{cyc + 2, monW.data});
        end
      end
      if (wdQ.size() > 0 && wdQ[0].due == cyc) begin
        monP = wdQ.pop_front();
        checkOutput("wr_data", bus.mem_wdata, monP.data);
      end
      if (bus.disp_gnt) readQ.push_back('{cyc + 4, lookup(bus.disp_addr)});
      if (bus.disp_rvalid) rvCount++;
      if (readQ.size() > 0 && readQ[0].due == cyc) begin
        monP = readQ.pop_front();
        checkOutput("rd_valid", bus.disp_rvalid, 1);
        checkOutput("rd_data", bus.disp_rdata, monP.data);
      end else if (bus.disp_rvalid) begin
        checkOutput("spurious_rvalid", bus.disp_rvalid, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int slotCyc[$];
    bit found;
    int rvBefore;

    reset            = 1'b1;
    bus.ntsc_we      = 1'b0;
    bus.ntsc_addr    = '0;
    bus.ntsc_data    = '0;
    bus.disp_req     = 1'b0;
    bus.disp_addr    = '0;
    bus.clr_overflow = 1'b0;
    mA1 = '0; mA2 = '0; mWe1 = 1'b0; mWe2 = 1'b0;
    memModel[19'h00020] = 36'h0000ABCDE;
    memModel[19'h00030] = 36'h111111111;
    memModel[19'h00031] = 36'h222222222;
    memModel[19'h00032] = 36'h333333333;
    memModel[19'h00040] = 36'h0F0F0F0F0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] single write, idle display");
    applyStimulus(19'h00010, 36'h123456789, 1'b0);
    @(negedge clk);
    checkOutput("t1_level", bus.fifo_level, 1);
    @(negedge clk);
    checkOutput("t1_we", bus.mem_we, 1);
    checkOutput("t1_addr", bus.mem_addr, 19'h00010);
    @(negedge clk);
    checkOutput("t1_we_low", bus.mem_we, 0);
    @(negedge clk);
    checkOutput("t1_wdata", bus.mem_wdata, 36'h123456789);
    tick();

    $display("[TB] read latency");
    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'h00020;
    @(negedge clk);
    checkOutput("t2_gnt", bus.disp_gnt, 1);
    tick();
    bus.disp_req = 1'b0;
    @(negedge clk);
    checkOutput("t2_mem_addr", bus.mem_addr, 19'h00020);
    checkOutput("t2_mem_we", bus.mem_we, 0);
    @(negedge clk);
    checkOutput("t2_rvalid_n2", bus.disp_rvalid, 0);
    @(negedge clk);
    checkOutput("t2_rvalid_n3", bus.disp_rvalid, 0);
    @(negedge clk);
    checkOutput("t2_rvalid_n4", bus.disp_rvalid, 1);
    checkOutput("t2_rdata", bus.disp_rdata, 36'h0000ABCDE);
    tick();
    for (int a = 'h30; a <= 'h32; a++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = AW'(a);
      tick();
    end
    bus.disp_req = 1'b0;
    repeat (6) tick();
    checkOutput("t2_reads_drained", readQ.size(), 0);

    $display("[TB] starvation guard");
    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'h00040;
    for (int i = 0; i < 3; i++) applyStimulus(AW'(19'h100 + i), DW'(36'h700000000 + i), 1'b0);
    for (int i = 0; i < 80 && slotCyc.size() < 3; i++) begin
      @(negedge clk);
      if (!bus.disp_gnt) slotCyc.push_back(cyc);
    end
    checkOutput("t3_slot_count", slotCyc.size(), 3);
    if (slotCyc.size() == 3) begin
      checkOutput("t3_gap1", slotCyc[1] - slotCyc[0], 17);
      checkOutput("t3_gap2", slotCyc[2] - slotCyc[1], 17);
    end
    tick();
    bus.disp_req = 1'b0;
    repeat (6) tick();
    checkOutput("t3_writes_done", writeQ.size() + wdQ.size(), 0);
    checkOutput("t3_reads_done", readQ.size(), 0);

    $display("[TB] overflow");
    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'h00040;
    for (int i = 0; i < 9; i++) applyStimulus(AW'(19'h200 + i), DW'(36'hA00000000 + i), i == 8);
    @(negedge clk);
    checkOutput("t4_level_full", bus.fifo_level, 8);
    checkOutput("t4_overflow_set", bus.overflow, 1);
    tick();
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    @(negedge clk);
    checkOutput("t4_overflow_clr", bus.overflow, 0);

    $display("[TB] full with pop and push together");
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.disp_gnt) begin
        bus.ntsc_we   = 1'b1;
        bus.ntsc_addr = 19'h002FF;
        bus.ntsc_data = 36'h00000BEEF;
        writeQ.push_back('{19'h002FF, 36'h00000BEEF});
        found = 1'b1;
        break;
      end
    end
    checkOutput("t5_slot_found", found, 1);
    tick();
    bus.ntsc_we = 1'b0;
    @(negedge clk);
    checkOutput("t5_level", bus.fifo_level, 8);
    checkOutput("t5_no_overflow", bus.overflow, 0);
    tick();
    bus.disp_req = 1'b0;
    repeat (14) tick();
    checkOutput("t5_drained", writeQ.size() + wdQ.size(), 0);
    checkOutput("t5_level_empty", bus.fifo_level, 0);
    checkOutput("t4_dropped_absent", memModel.exists(19'h00208), 0);

    $display("[TB] reset mid-read");
    rvBefore = rvCount;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'h00020;
    tick();
    bus.disp_req = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("t6_reset");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t6_no_rvalid", bus.disp_rvalid, 0);
    end
    checkOutput("t6_rvalid_count", rvCount - rvBefore, 0);
    tick();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'h00031;
    @(negedge clk);
    checkOutput("t6_gnt_after", bus.disp_gnt, 1);
    tick();
    bus.disp_req = 1'b0;
    repeat (6) tick();
    checkOutput("t6_rvalid_after", rvCount - rvBefore, 1);
    checkOutput("t6_reads_done", readQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
